// File: rtl/loop_sequencer.sv
// loop_sequencer: program-address sequencer with a zero-overhead loop stack.
//
// Each enabled cycle it does one of the following, highest priority first:
//   flush      empty the stack, pc <= pc+1
//   loop_valid push a loop (or reject it / skip a zero-count body)
//   jump_valid pc <= jump_addr
//   loop-back  when pc hits top.end: branch to top.start or pop on the last pass
//   otherwise  pc <= pc+1 (wraps modulo 2^ADDR_W)
//
// Ports
//   clk, reset_n            clock, async active-low reset
//   en                      advance enable; 0 freezes all state
//   flush                   clear the loop stack
//   loop_valid/start/end/count  loop push request
//   jump_valid/jump_addr    absolute jump request
//   err_clr                 clear sticky error flags
//   pc                      registered program address
//   depth                   registered active loop count
//   loop_ready              en & stack not full (combinational)
//   loop_exit               one-cycle pulse when a loop terminates
//   err                     sticky {malformed, overflow}

// One stack slot: holds {start, end, remaining} for one active loop.
module loop_sequencer_entry #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              dec,
  input  logic [ADDR_W-1:0] ld_start,
  input  logic [ADDR_W-1:0] ld_stop,
  input  logic [CNT_W-1:0]  ld_rem,
  output logic [ADDR_W-1:0] start,
  output logic [ADDR_W-1:0] stop,
  output logic [CNT_W-1:0]  rem
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start <= '0;
      stop  <= '0;
      rem   <= '0;
    end else if (load) begin
      start <= ld_start;
      stop  <= ld_stop;
      rem   <= ld_rem;
    end else if (dec) begin
      rem   <= rem - CNT_W'(1);
    end
  end
endmodule

module loop_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 8,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       loop_valid,
  input  logic [ADDR_W-1:0]          loop_start,
  input  logic [ADDR_W-1:0]          loop_end,
  input  logic [CNT_W-1:0]           loop_count,
  input  logic                       jump_valid,
  input  logic [ADDR_W-1:0]          jump_addr,
  input  logic                       err_clr,
  output logic [ADDR_W-1:0]          pc,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       loop_ready,
  output logic                       loop_exit,
  output logic [1:0]                 err
);
  localparam int DW = $clog2(DEPTH+1);

  // stack storage, slot i holds the loop pushed at depth i
  logic [DEPTH-1:0][ADDR_W-1:0] st_start, st_stop;
  logic [DEPTH-1:0][CNT_W-1:0]  st_rem;

  logic [ADDR_W-1:0] top_start, top_stop;
  logic [CNT_W-1:0]  top_rem;
  logic              have_top, full;

  logic [ADDR_W-1:0] pc_n;
  logic [DW-1:0]     depth_n;
  logic              exit_n;
  logic [1:0]        err_set, err_n;
  logic              push, dec;

  assign have_top   = (depth != '0);
  assign full       = (depth == DW'(DEPTH));
  assign loop_ready = en & ~full;

  // top-of-stack is slot depth-1; mux by depth so an empty stack reads zero
  always_comb begin
    top_start = '0;
    top_stop  = '0;
    top_rem   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth == DW'(i+1)) begin
        top_start = st_start[i];
        top_stop  = st_stop[i];
        top_rem   = st_rem[i];
      end
    end
  end

  always_comb begin
    pc_n    = pc;
    depth_n = depth;
    exit_n  = 1'b0;
    err_set = 2'b00;
    push    = 1'b0;
    dec     = 1'b0;
    if (en) begin
      pc_n = pc + ADDR_W'(1);
      if (flush) begin
        depth_n = '0;
      end else if (loop_valid) begin
        // inner loops must end strictly before the enclosing loop so at
        // most one pop can happen per cycle
        if ((loop_end < loop_start) || (have_top && (loop_end >= top_stop))) begin
          err_set[1] = 1'b1;
        end else if (full) begin
          err_set[0] = 1'b1;
        end else if (loop_count == '0) begin
          pc_n = loop_end + ADDR_W'(1);
        end else begin
          push    = 1'b1;
          pc_n    = loop_start;
          depth_n = depth + DW'(1);
        end
      end else if (jump_valid) begin
        pc_n = jump_addr;
      end else if (have_top && (pc == top_stop)) begin
        if (top_rem > CNT_W'(1)) begin
          dec  = 1'b1;
          pc_n = top_start;
        end else begin
          depth_n = depth - DW'(1);
          exit_n  = 1'b1;
        end
      end
    end
  end

  // a fresh error in the same cycle overrides err_clr
  assign err_n = en ? ((err_clr ? 2'b00 : err) | err_set) : err;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stk
    loop_sequencer_entry #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_ent (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (push && (depth == DW'(g))),
      .dec      (dec  && (depth == DW'(g+1))),
      .ld_start (loop_start),
      .ld_stop  (loop_end),
      .ld_rem   (loop_count),
      .start    (st_start[g]),
      .stop     (st_stop[g]),
      .rem      (st_rem[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= ADDR_W'(RESET_PC);
      depth     <= '0;
      loop_exit <= 1'b0;
      err       <= 2'b00;
    end else begin
      pc        <= pc_n;
      depth     <= depth_n;
      loop_exit <= exit_n;
      err       <= err_n;
    end
  end
endmodule

// File: tb/tb_loop_sequencer.sv
module tb_loop_sequencer;
  logic       clk = 1'b0;
  logic       reset_n, en, flush, loop_valid, jump_valid, err_clr;
  logic [4:0] loop_start, loop_end, jump_addr, pc;
  logic [7:0] loop_count;
  logic [2:0] depth;
  logic       loop_ready, loop_exit;
  logic [1:0] err;

  loop_sequencer #(.ADDR_W(5), .CNT_W(8), .DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush),
    .loop_valid(loop_valid), .loop_start(loop_start), .loop_end(loop_end),
    .loop_count(loop_count), .jump_valid(jump_valid), .jump_addr(jump_addr),
    .err_clr(err_clr), .pc(pc), .depth(depth), .loop_ready(loop_ready),
    .loop_exit(loop_exit), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] tag;
    logic [4:0]  pc;
    logic [2:0]  dp;
    logic        ex;
    logic [1:0]  er;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  task automatic chk(input string nm, input int tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s step=%0d got=%0d want=%0d", nm, tag, got, want);
    end
  endtask

  // monitor: compare registered outputs mid-cycle against queued expectations
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc",        e.tag, int'(pc),        int'(e.pc));
      chk("depth",     e.tag, int'(depth),     int'(e.dp));
      chk("loop_exit", e.tag, int'(loop_exit), int'(e.ex));
      chk("err",       e.tag, int'(err),       int'(e.er));
    end
  end

  task automatic expect_state(input logic [4:0] p, input logic [2:0] d,
                              input logic x, input logic [1:0] e);
    exp_t v;
    step++;
    v.tag = step; v.pc = p; v.dp = d; v.ex = x; v.er = e;
    q.push_back(v);
  endtask

  // advance one edge and queue the state expected after it
  task automatic tk(input logic [4:0] p, input logic [2:0] d,
                    input logic x, input logic [1:0] e);
    @(posedge clk); #1;
    expect_state(p, d, x, e);
  endtask

  task automatic idle();
    flush = 0; loop_valid = 0; jump_valid = 0; err_clr = 0;
  endtask

  task automatic req(input logic [4:0] s, input logic [4:0] e, input logic [7:0] c);
    loop_valid = 1; loop_start = s; loop_end = e; loop_count = c;
  endtask

  int sl[8] = '{5, 6, 4, 5, 6, 4, 5, 6};

  initial begin
    reset_n = 0; en = 1; loop_start = 0; loop_end = 0; loop_count = 0;
    jump_addr = 0; idle();
    #1 expect_state(0, 0, 0, 0);
    @(negedge clk); #1 reset_n = 1;

    // reset release and free-running wrap
    for (int k = 1; k <= 33; k++) tk(5'(k), 0, 0, 0);

    // single loop (4..6) x3 pushed at pc=3
    tk(2, 0, 0, 0); tk(3, 0, 0, 0);
    req(4, 6, 3); tk(4, 1, 0, 0); idle();
    for (int i = 0; i < 8; i++) tk(5'(sl[i]), 1, 0, 0);
    tk(7, 0, 1, 0); tk(8, 0, 0, 0);

    // nested: outer (2,8,2), inner (4,5,2) pushed at every pc=3
    jump_valid = 1; jump_addr = 1; tk(1, 0, 0, 0); idle();
    req(2, 8, 2); tk(2, 1, 0, 0); idle();
    for (int r = 0; r < 2; r++) begin
      if (r == 1) tk(2, 1, 0, 0);
      tk(3, 1, 0, 0);
      req(4, 5, 2); tk(4, 2, 0, 0); idle();
      tk(5, 2, 0, 0); tk(4, 2, 0, 0); tk(5, 2, 0, 0);
      tk(6, 1, 1, 0); tk(7, 1, 0, 0); tk(8, 1, 0, 0);
    end
    tk(9, 0, 1, 0);

    // overflow: four nested pushes fill the stack, fifth is rejected
    req(10, 30, 5); tk(10, 1, 0, 0);
    req(11, 29, 5); tk(11, 2, 0, 0);
    req(12, 28, 5); tk(12, 3, 0, 0);
    req(13, 27, 5); tk(13, 4, 0, 0);
    req(14, 26, 5); #1 chk("loop_ready_full", step, int'(loop_ready), 0);
    tk(14, 4, 0, 2'b01); idle();
    err_clr = 1; tk(15, 4, 0, 2'b00); idle();
    flush = 1; tk(16, 0, 0, 0); idle();
    #1 chk("loop_ready_empty", step, int'(loop_ready), 1);

    // boundaries
    req(20, 31, 0); tk(0, 0, 0, 0);          // zero count, end+1 wraps
    req(5, 3, 2);   tk(1, 0, 0, 2'b10); idle(); // end < start
    err_clr = 1;    tk(2, 0, 0, 2'b00); idle();
    req(3, 9, 2);   tk(3, 1, 0, 0);
    req(4, 9, 2); err_clr = 1; tk(4, 1, 0, 2'b10); idle(); // equal end, error beats clr
    err_clr = 1;    tk(5, 1, 0, 2'b00); idle();
    req(6, 7, 2); jump_valid = 1; jump_addr = 20; tk(6, 2, 0, 0); idle();
    tk(7, 2, 0, 0); tk(6, 2, 0, 0); tk(7, 2, 0, 0);
    tk(8, 1, 1, 0); tk(9, 1, 0, 0); tk(3, 1, 0, 0); tk(4, 1, 0, 0);

    // hold inside loop (3,9); requests ignored while en=0
    en = 0; jump_valid = 1; jump_addr = 20;
    #1 chk("loop_ready_en0", step, int'(loop_ready), 0);
    tk(4, 1, 0, 0); tk(4, 1, 0, 0); tk(4, 1, 0, 0);
    en = 1; idle();
    tk(5, 1, 0, 0); tk(6, 1, 0, 0); tk(7, 1, 0, 0); tk(8, 1, 0, 0); tk(9, 1, 0, 0);
    tk(10, 0, 1, 0);

    // async reset mid-loop
    req(12, 14, 3); tk(12, 1, 0, 0); idle();
    tk(13, 1, 0, 0);
    @(negedge clk); #1 reset_n = 0;
    #1;
    chk("rst_pc",    step, int'(pc),    0);
    chk("rst_depth", step, int'(depth), 0);
    @(negedge clk); #1 reset_n = 1;
    tk(1, 0, 0, 0); tk(2, 0, 0, 0);

    begin
      int n;
      n = 0;
      while (q.size() != 0 && n < 10) begin
        @(posedge clk); n++;
      end
      if (q.size() != 0) begin
        checks++; errors++;
        $display("FAIL drain pending=%0d want=0", q.size());
      end
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
